// File: rtl/parity_tx.sv
// Odd-parity serial transmitter: start, 8 data bits (din[0] first), parity, stop.
// Define PARITY_ERR_INJECT_EN to add the inj input, which inverts one frame's parity bit.
module parity_tx #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [0:7] din,
    input  logic       wr,
`ifdef PARITY_ERR_INJECT_EN
    input  logic       inj,
`endif
    output logic       sout,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

    logic [2:0] state_q;
    logic [7:0] cnt_q;
    logic [2:0] idx_q;
    logic [0:7] shreg_q;
    logic       par_q;
    logic       sout_q;
    logic       busy_q;
    logic       done_q;
    logic       flip;
    logic       bit_end;

`ifdef PARITY_ERR_INJECT_EN
    assign flip = inj;
`else
    assign flip = 1'b0;
`endif

    assign bit_end = (cnt_q == LAST);

    // Outputs are registered so sout is glitch-free and moves only on bit boundaries.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            idx_q   <= 3'd0;
            shreg_q <= 8'd0;
            par_q   <= 1'b0;
            sout_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (wr) begin
                        state_q <= START;
                        cnt_q   <= 8'd0;
                        idx_q   <= 3'd0;
                        shreg_q <= din;
                        par_q   <= (~^din) ^ flip;
                        sout_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cnt_q   <= 8'd0;
                        state_q <= DATA;
                        sout_q  <= shreg_q[0];
                        shreg_q <= {shreg_q[1:7], 1'b0};
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt_q <= 8'd0;
                        if (idx_q == 3'd7) begin
                            idx_q   <= 3'd0;
                            state_q <= PARITY;
                            sout_q  <= par_q;
                        end else begin
                            idx_q   <= idx_q + 3'd1;
                            sout_q  <= shreg_q[0];
                            shreg_q <= {shreg_q[1:7], 1'b0};
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        cnt_q   <= 8'd0;
                        state_q <= STOP;
                        sout_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt_q   <= 8'd0;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= 8'd0;
                    sout_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign sout = sout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_parity_tx.sv
// Scoreboard bench for parity_tx: expected frames queued at WR, compared by a line monitor.
// Define PARITY_ERR_INJECT_EN to also exercise the parity-corrupt input.
module tb_parity_tx;

    localparam int unsigned CPB = 4;

    bit         clk;
    logic       rstn;
    logic [0:7] din;
    logic       wr;
`ifdef PARITY_ERR_INJECT_EN
    logic       inj;
`endif
    logic       sout;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    parity_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk  (clk),
        .rstn (rstn),
        .din  (din),
        .wr   (wr),
`ifdef PARITY_ERR_INJECT_EN
        .inj  (inj),
`endif
        .sout (sout),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Frame in send order: bit 0 = start, 1..8 = data, 9 = parity, 10 = stop.
    function automatic logic [10:0] make_frame(input logic [0:7] d, input logic flip);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1+i] = d[i];
        f[9]  = (~^d) ^ flip;
        f[10] = 1'b1;
        return f;
    endfunction

    logic [11:0] sb[$];

    // Line monitor: sample once per cycle on the falling edge.
    logic        rst_prev = 1'b0;
    bit          in_frame = 1'b0;
    bit          exp_done = 1'b0;
    int          pos;
    bit          stable;
    logic [10:0] got;
    logic [11:0] e;
    logic        perr;

    always @(posedge clk) rst_prev <= rstn;

    always @(negedge clk) begin
        if (!rst_prev) begin
            check_eq("rst_sout", 32'(sout), 32'd1);
            check_eq("rst_busy", 32'(busy), 32'd0);
            check_eq("rst_done", 32'(done), 32'd0);
            if (in_frame) begin
                in_frame = 1'b0;
                if (sb.size() > 0) void'(sb.pop_front());
            end
            exp_done = 1'b0;
        end else begin
            check_eq("done", 32'(done), 32'(exp_done));
            exp_done = 1'b0;
            if (!busy && !in_frame) check_eq("idle_sout", 32'(sout), 32'd1);
            if (!in_frame && busy) begin
                in_frame = 1'b1;
                pos      = 0;
                stable   = 1'b1;
                got      = '0;
                check_eq("expected_frame", 32'(sb.size() > 0), 32'd1);
            end
            if (in_frame) begin
                check_eq("busy_in_frame", 32'(busy), 32'd1);
                if (pos % CPB == 0) got[pos/CPB] = sout;
                else if (sout !== got[pos/CPB]) stable = 1'b0;
                pos++;
                if (pos == 11 * CPB) begin
                    in_frame = 1'b0;
                    exp_done = 1'b1;
                    check_eq("bit_stable", 32'(stable), 32'd1);
                    if (sb.size() > 0) begin
                        e    = sb.pop_front();
                        perr = ~(^got[9:1]);
                        check_eq("frame", 32'(got), 32'(e[10:0]));
                        check_eq("parity_flag", 32'(perr), 32'(e[11]));
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send(input logic [0:7] d, input logic flip);
        din = d;
        wr  = 1'b1;
`ifdef PARITY_ERR_INJECT_EN
        inj = flip;
`endif
        sb.push_back({flip, make_frame(d, flip)});
        tick(1);
        wr = 1'b0;
`ifdef PARITY_ERR_INJECT_EN
        inj = 1'b0;
`endif
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while ((sb.size() != 0 || in_frame || busy) && n < max) begin
            tick(1);
            n++;
        end
        check_eq("idle_timeout", 32'(n < max), 32'd1);
        tick(3);
    endtask

    initial begin
        int n;
        rstn = 1'b0;
        wr   = 1'b0;
        din  = 8'h00;
`ifdef PARITY_ERR_INJECT_EN
        inj  = 1'b0;
`endif
        tick(2);
        // WR during reset must be dropped.
        wr  = 1'b1;
        din = 8'hFF;
        tick(2);
        wr   = 1'b0;
        rstn = 1'b1;
        tick(3);
        check_eq("wr_in_reset", 32'(busy), 32'd0);

        // Basic frame plus start latency and DONE timing.
        send(8'hA5, 1'b0);
        check_eq("start_sout", 32'(sout), 32'd0);
        check_eq("start_busy", 32'(busy), 32'd1);
        n = 0;
        while (!done && n < 100) begin
            tick(1);
            n++;
        end
        check_eq("done_latency", 32'(n), 32'(11 * CPB));
        wait_idle(200);

        send(8'h07, 1'b0);
        wait_idle(200);
        send(8'h00, 1'b0);
        wait_idle(200);
        send(8'hFF, 1'b0);
        wait_idle(200);

        // WR and DIN changes mid-frame are ignored.
        send(8'h5A, 1'b0);
        tick(4);
        din = 8'hC3;
        wr  = 1'b1;
        tick(1);
        wr = 1'b0;
        tick(14);
        din = 8'h81;
        wr  = 1'b1;
        tick(1);
        wr = 1'b0;
        wait_idle(200);

        // WR held: three frames back to back.
        din = 8'h3C;
        wr  = 1'b1;
        sb.push_back({1'b0, make_frame(8'h3C, 1'b0)});
        tick(1);
        for (int f = 0; f < 3; f++) begin
            n = 0;
            while (!done && n < 100) begin
                tick(1);
                n++;
            end
            check_eq("b2b_done_seen", 32'(done), 32'd1);
            if (f < 2) begin
                sb.push_back({1'b0, make_frame(8'h3C, 1'b0)});
                tick(1);
                check_eq("b2b_start_busy", 32'(busy), 32'd1);
                check_eq("b2b_start_sout", 32'(sout), 32'd0);
            end else begin
                wr = 1'b0;
            end
        end
        wait_idle(300);

        // Reset during data bit 3 aborts, then a fresh frame goes out.
        send(8'h96, 1'b0);
        tick(17);
        rstn = 1'b0;
        tick(1);
        check_eq("abort_sout", 32'(sout), 32'd1);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        rstn = 1'b1;
        tick(3);
        check_eq("abort_stays_idle", 32'(busy), 32'd0);
        send(8'h96, 1'b0);
        wait_idle(200);

`ifdef PARITY_ERR_INJECT_EN
        send(8'hA5, 1'b1);
        wait_idle(200);
        send(8'hA5, 1'b0);
        wait_idle(200);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
